// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multicycle core: IF -> ID -> EX -> MEM -> WB,
// with decode latching, data-memory handshake with timeout, and illegal-op flagging.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dmem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        loadPC,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_IALU = 3'd2;
  localparam logic [2:0] C_LW   = 3'd3;
  localparam logic [2:0] C_SW   = 3'd4;
  localparam logic [2:0] C_BEQ  = 3'd5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [3:0] alu_q, alu_d;
  logic       zero_q, zero_d;
  logic [7:0] wait_q, wait_d;
  logic       tout_q, tout_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [2:0] dec_cls;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       is_mem, in_exec, wait_expired;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_cls   = C_NOP;
    dec_alu   = ALU_AND;
    dec_legal = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_cls   = C_R;
        dec_alu   = alu_from_f3(funct3, instr[30]);
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      7'b0010011: begin
        dec_cls   = C_IALU;
        dec_alu   = (funct3 == 3'b000) ? ALU_ADD : alu_from_f3(funct3, instr[30]);
        dec_legal = 1'b1;
      end
      7'b0000011: begin
        dec_cls   = C_LW;
        dec_alu   = ALU_ADD;
        dec_legal = (funct3 == 3'b010);
      end
      7'b0100011: begin
        dec_cls   = C_SW;
        dec_alu   = ALU_ADD;
        dec_legal = (funct3 == 3'b010);
      end
      7'b1100011: begin
        dec_cls   = C_BEQ;
        dec_alu   = ALU_SUB;
        dec_legal = (funct3 == 3'b000);
      end
      default: ;
    endcase
    // Illegal instructions run through the FSM as a NOP.
    if (!dec_legal) begin
      dec_cls = C_NOP;
      dec_alu = ALU_AND;
    end
  end

  assign is_mem       = (cls_q == C_LW) || (cls_q == C_SW);
  assign wait_expired = (state_q == S_MEM) && is_mem && !dmem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    zero_d  = zero_q;
    wait_d  = wait_q;
    tout_d  = tout_q;
    case (state_q)
      S_IF: begin
        state_d = S_ID;
        tout_d  = 1'b0;
      end
      S_ID: begin
        state_d = S_EX;
        cls_d   = dec_cls;
        alu_d   = dec_alu;
      end
      S_EX: begin
        state_d = S_MEM;
        zero_d  = Zero;
      end
      S_MEM: begin
        if (!is_mem || dmem_ready) begin
          state_d = S_WB;
          wait_d  = 8'd0;
        end else if (wait_expired) begin
          state_d = S_WB;
          wait_d  = 8'd0;
          tout_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      cls_q   <= C_NOP;
      alu_q   <= ALU_AND;
      zero_q  <= 1'b0;
      wait_q  <= 8'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
    end
  end

  assign in_exec = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

  assign ALUCtrl     = alu_q;
  assign ALUSrc      = in_exec && (cls_q == C_IALU || cls_q == C_LW || cls_q == C_SW);
  assign MemToReg    = in_exec && (cls_q == C_LW);
  assign loadPC      = (state_q == S_WB);
  assign PCSrc       = (state_q == S_WB) && (cls_q == C_BEQ) && zero_q;
  assign RegWrite    = (state_q == S_WB) &&
                       (cls_q == C_R || cls_q == C_IALU || (cls_q == C_LW && !tout_q));
  assign MemRead     = (state_q == S_MEM) && (cls_q == C_LW);
  assign MemWrite    = (state_q == S_MEM) && (cls_q == C_SW);
  assign illegal     = (state_q == S_ID) && !dec_legal;
  assign mem_timeout = wait_expired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction vector table with
// hand-computed expectations, plus asynchronous-reset corner sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        dmem_ready;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC;
  logic [3:0]  ALUCtrl;
  logic        MemRead, MemWrite, illegal, mem_timeout;

  multicycle_ctrl #(.MEM_WAIT_MAX(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dmem_ready(dmem_ready),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .loadPC(loadPC), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // rdy_wait: MEM cycles with dmem_ready low before it rises; -1 = never rises.
  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          rdy_wait;
    int          cycles;
    logic        chk_alu;
    logic [3:0]  alu;
    logic        alusrc;
    logic        m2r;
    int          rw;
    logic        pcsrc;
    int          ill;
    int          tout;
    int          mrd;
    int          mwr;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec;
  int          n_miss;
  logic [31:0] cur_instr;
  logic        prev_valid;
  logic [3:0]  prev_alu;

  function automatic vec_t mk(logic [31:0] i, logic z, int rdy, int cyc, logic ca, logic [3:0] a,
                              logic as, logic m2, int rw, logic pc, int il, int to, int rd, int wr);
    vec_t v;
    v.instr = i; v.zero = z; v.rdy_wait = rdy; v.cycles = cyc; v.chk_alu = ca; v.alu = a;
    v.alusrc = as; v.m2r = m2; v.rw = rw; v.pcsrc = pc; v.ill = il; v.tout = to;
    v.mrd = rd; v.mwr = wr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s instr=%h: got %0d expected %0d", name, cur_instr, act, exp);
    end
  endtask

  function automatic int out_bus();
    return int'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl,
                 MemRead, MemWrite, illegal, mem_timeout});
  endfunction

  // Runs one instruction starting in IF (called just after a falling edge).
  task automatic run_vec(input vec_t v);
    int n_cyc, rw_cnt, rw_bad, mrd, mwr, both, ill_id, ill_other, tout, tout_cyc;
    int early_bad, alu_moved;
    logic [3:0] alu_ex, alu_id;
    logic alusrc_ex, m2r_ex, pcsrc_wb, done;
    n_cyc = 0; rw_cnt = 0; rw_bad = 0; mrd = 0; mwr = 0; both = 0; ill_id = 0;
    ill_other = 0; tout = 0; tout_cyc = 0; early_bad = 0; alu_moved = 0;
    alu_ex = 4'd0; alu_id = 4'd0; alusrc_ex = 1'b0; m2r_ex = 1'b0; pcsrc_wb = 1'b0;
    done = 1'b0;
    instr = v.instr;
    cur_instr = v.instr;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      Zero = (cyc == 3) ? v.zero : ~v.zero;
      dmem_ready = (v.rdy_wait < 0) ? 1'b0 : (cyc >= 4 + v.rdy_wait);
      #1;
      if (cyc == 2) alu_id = ALUCtrl;
      if (cyc == 3) begin
        alu_ex = ALUCtrl; alusrc_ex = ALUSrc; m2r_ex = MemToReg;
      end
      if (cyc > 3 && ALUCtrl !== alu_ex) alu_moved++;
      if (cyc <= 2 && (ALUSrc | MemToReg | RegWrite | MemRead | MemWrite | loadPC | PCSrc |
                       mem_timeout)) early_bad++;
      if (RegWrite) begin
        rw_cnt++;
        if (!loadPC) rw_bad++;
      end
      mrd += int'(MemRead);
      mwr += int'(MemWrite);
      both += int'(MemRead & MemWrite);
      if (illegal) begin
        if (cyc == 2) ill_id++;
        else ill_other++;
      end
      if (mem_timeout) begin
        tout++;
        tout_cyc = cyc;
      end
      if (loadPC) begin
        n_cyc = cyc; pcsrc_wb = PCSrc; done = 1'b1;
      end
      @(negedge clk);
    end
    check("cycles", n_cyc, v.cycles);
    if (v.chk_alu) check("alu_ex", int'(alu_ex), int'(v.alu));
    check("alu_held", alu_moved, 0);
    if (prev_valid) check("alu_in_id_is_previous", int'(alu_id), int'(prev_alu));
    check("alusrc", int'(alusrc_ex), int'(v.alusrc));
    check("memtoreg", int'(m2r_ex), int'(v.m2r));
    check("regwrite_wb", rw_cnt, v.rw);
    check("regwrite_outside_wb", rw_bad, 0);
    check("pcsrc_wb", int'(pcsrc_wb), int'(v.pcsrc));
    check("memread_cycles", mrd, v.mrd);
    check("memwrite_cycles", mwr, v.mwr);
    check("rd_wr_overlap", both, 0);
    check("illegal_in_id", ill_id, v.ill);
    check("illegal_elsewhere", ill_other, 0);
    check("mem_timeout", tout, v.tout);
    if (v.tout != 0) check("mem_timeout_cycle", tout_cyc, v.cycles - 1);
    check("outputs_in_if_id", early_bad, 0);
    prev_valid = v.chk_alu;
    prev_alu   = v.alu;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cur_instr = 32'd0;
    prev_valid = 1'b1; prev_alu = 4'b0000;
    rst = 1'b1; instr = 32'd0; Zero = 1'b0; dmem_ready = 1'b0;

    //        instr         z  rdy cyc ca alu      as m2 rw pc il to rd wr
    tbl.push_back(mk(32'h002081B3, 0, -1, 5, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0)); // ADD
    tbl.push_back(mk(32'h402081B3, 1, -1, 5, 1, 4'b1000, 0, 0, 1, 0, 0, 0, 0, 0)); // SUB
    tbl.push_back(mk(32'h002091B3, 0,  0, 5, 1, 4'b0011, 0, 0, 1, 0, 0, 0, 0, 0)); // SLL
    tbl.push_back(mk(32'h0020A1B3, 0, -1, 5, 1, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 0)); // SLT
    tbl.push_back(mk(32'h0020B1B3, 0, -1, 5, 1, 4'b0101, 0, 0, 1, 0, 0, 0, 0, 0)); // SLTU
    tbl.push_back(mk(32'h0020C1B3, 0, -1, 5, 1, 4'b0110, 0, 0, 1, 0, 0, 0, 0, 0)); // XOR
    tbl.push_back(mk(32'h0020D1B3, 0, -1, 5, 1, 4'b0111, 0, 0, 1, 0, 0, 0, 0, 0)); // SRL
    tbl.push_back(mk(32'h4020D1B3, 0, -1, 5, 1, 4'b1010, 0, 0, 1, 0, 0, 0, 0, 0)); // SRA
    tbl.push_back(mk(32'h0020E1B3, 0, -1, 5, 1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0)); // OR
    tbl.push_back(mk(32'h0020F1B3, 0, -1, 5, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0)); // AND
    tbl.push_back(mk(32'h4020F1B3, 1, -1, 5, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)); // bad funct3 w/ 0100000
    tbl.push_back(mk(32'h022081B3, 0, -1, 5, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)); // MUL: bad funct7
    tbl.push_back(mk(32'h00108093, 0, -1, 5, 1, 4'b0010, 1, 0, 1, 0, 0, 0, 0, 0)); // ADDI
    tbl.push_back(mk(32'h40008093, 0, -1, 5, 1, 4'b0010, 1, 0, 1, 0, 0, 0, 0, 0)); // ADDI, bit30 set
    tbl.push_back(mk(32'h4010D093, 0, -1, 5, 1, 4'b1010, 1, 0, 1, 0, 0, 0, 0, 0)); // SRAI
    tbl.push_back(mk(32'h0010C093, 0, -1, 5, 1, 4'b0110, 1, 0, 1, 0, 0, 0, 0, 0)); // XORI
    tbl.push_back(mk(32'h0080A283, 0,  2, 7, 1, 4'b0010, 1, 1, 1, 0, 0, 0, 3, 0)); // LW, 2 waits
    tbl.push_back(mk(32'h0080A283, 0,  0, 5, 1, 4'b0010, 1, 1, 1, 0, 0, 0, 1, 0)); // LW, ready at once
    tbl.push_back(mk(32'h0080C283, 0,  0, 5, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)); // LBU: illegal
    tbl.push_back(mk(32'h0020A223, 0, -1, 12, 1, 4'b0010, 1, 0, 0, 0, 0, 1, 0, 8)); // SW timeout
    tbl.push_back(mk(32'h0020A223, 0,  1, 6, 1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 2)); // SW, 1 wait
    tbl.push_back(mk(32'h0020A223, 0,  7, 12, 1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 8)); // ready on last allowed cycle
    tbl.push_back(mk(32'h0080A283, 0, -1, 12, 1, 4'b0010, 1, 1, 0, 0, 0, 1, 8, 0)); // LW timeout
    tbl.push_back(mk(32'h00208463, 1, -1, 5, 1, 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0)); // BEQ taken
    tbl.push_back(mk(32'h00208463, 0, -1, 5, 1, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0)); // BEQ not taken
    tbl.push_back(mk(32'h00209463, 1, -1, 5, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)); // BNE: illegal
    tbl.push_back(mk(32'h0000007F, 1,  0, 5, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)); // unknown opcode

    #1 rst = 1'b0;
    #1 check("reset_outputs", out_bus(), 0);
    @(negedge clk);
    check("reset_held_outputs", out_bus(), 0);
    rst = 1'b1;

    foreach (tbl[k]) run_vec(tbl[k]);

    // Asynchronous reset in the middle of EX, then a clean 5-cycle restart.
    instr = 32'h002081B3; cur_instr = instr; Zero = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("alu_before_reset_ex", int'(ALUCtrl), 2);
    rst = 1'b0;
    #1 check("async_reset_ex", out_bus(), 0);
    @(negedge clk);
    #1 check("reset_ex_held", out_bus(), 0);
    rst = 1'b1;
    prev_valid = 1'b1; prev_alu = 4'b0000;
    run_vec(tbl[0]);

    // Reset during a stalled store; the wait counter must restart from zero.
    instr = 32'h0020A223; cur_instr = instr; Zero = 1'b0; dmem_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("memwrite_before_reset", int'(MemWrite), 1);
    rst = 1'b0;
    #1 check("async_reset_mem", out_bus(), 0);
    @(negedge clk);
    #1 check("reset_mem_held", out_bus(), 0);
    rst = 1'b1;
    prev_valid = 1'b1; prev_alu = 4'b0000;
    run_vec(tbl[19]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
